rtlola_input_stager: RTL and testbench

Per-input event front end for generated RTLola monitors. Captures input events (multiple input streams, per-stream presence bits), timestamps and queues them, and releases each event to the monitor so that it is presented exactly at stage 0 of the LLC/HLC phase cycle. Stage alignment therefore no longer depends on the stimulus source. Sits between the input ports of the top entity and the monitor's HLC, and generalises the single-input, hand-aligned `new_input` scheme to N inputs and configurable stage count.

---
 rtl/rtlola_stager_pkg.sv | 19 +
 rtl/rtlola_stager_fifo.sv | 53 +++++
 rtl/rtlola_input_stager.sv | 137 +++++++++++++
 tb/tb_rtlola_input_stager.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rtlola_stager_pkg.sv
// Shared defaults and elaboration helpers for the RTLola input stager.
// Timestamp support is selected in the top by RTLOLA_STAGER_TIMESTAMP_EN.
package rtlola_stager_pkg;

  localparam int DEF_NUM_INPUTS = 2;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_STAGES     = 4;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_TIME_W     = 64;

  function automatic int stage_width(input int stages);
    return (stages > 2) ? $clog2(stages) : 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/rtlola_stager_fifo.sv
// Synchronous show-ahead FIFO: rd_data always shows the head entry.
// Holds the captured input events until their stage-0 release.
module rtlola_stager_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rtlola_input_stager.sv
// Multi-input event front end: queues input events and presents each one in a stage-0 cycle.
// Define RTLOLA_STAGER_TIMESTAMP_EN to build the timer and per-event timestamps.
module rtlola_input_stager
  import rtlola_stager_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STAGES     = DEF_STAGES,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int TIME_W     = DEF_TIME_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_INPUTS*DATA_W-1:0]   in_data,
  input  logic [NUM_INPUTS-1:0]          in_valid,
  input  logic                           in_new,
  output logic                           in_ready,
  output logic [stage_width(STAGES)-1:0] stage,
  output logic                           hlc_tick,
  output logic                           ev_new,
  output logic [NUM_INPUTS-1:0]          ev_valid,
  output logic [NUM_INPUTS*DATA_W-1:0]   ev_data,
  output logic [TIME_W-1:0]              ev_time,
  output logic                           overflow
);

  localparam int SW        = stage_width(STAGES);
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int PAYLOAD_W = NUM_INPUTS + NUM_INPUTS * DATA_W;
`ifdef RTLOLA_STAGER_TIMESTAMP_EN
  localparam int ENTRY_W   = PAYLOAD_W + TIME_W;
`else
  localparam int ENTRY_W   = PAYLOAD_W;
`endif
  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("rtlola_input_stager: DEPTH must be a power of two >= 2");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("rtlola_input_stager: STAGES must be >= 2");
  end

  logic [ENTRY_W-1:0]           wr_entry;
  logic [ENTRY_W-1:0]           rd_entry;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [CW-1:0]                fifo_count;
  logic                         event_seen;
  logic                         push;
  logic                         pop;
  logic [NUM_INPUTS-1:0]        head_valid;
  logic [NUM_INPUTS*DATA_W-1:0] head_data;

  assign in_ready   = (fifo_count < CW'(DEPTH));
  assign event_seen = in_new && (|in_valid);
  assign push       = event_seen && in_ready;
  // Pop decision uses pre-edge occupancy so an event arriving on the last stage waits a full HLC cycle.
  assign pop        = en && (stage == LAST_STAGE) && !fifo_empty;
  assign hlc_tick   = en && (stage == '0);

  rtlola_stager_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else if (en) begin
      stage <= (stage == LAST_STAGE) ? '0 : stage + SW'(1);
    end
  end

`ifdef RTLOLA_STAGER_TIMESTAMP_EN
  logic [TIME_W-1:0] timer;
  logic [TIME_W-1:0] head_time;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (en) begin
      timer <= timer + TIME_W'(1);
    end
  end

  assign wr_entry = {timer, in_valid, in_data};
  assign {head_time, head_valid, head_data} = rd_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_time <= '0;
    end else if (pop) begin
      ev_time <= head_time;
    end
  end
`else
  assign wr_entry = {in_valid, in_data};
  assign {head_valid, head_data} = rd_entry;
  assign ev_time  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_new   <= 1'b0;
      ev_valid <= '0;
      ev_data  <= '0;
    end else if (pop) begin
      ev_new   <= 1'b1;
      ev_valid <= head_valid;
      ev_data  <= head_data;
    end else begin
      ev_new   <= 1'b0;
      ev_valid <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (event_seen && fifo_full) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rtlola_input_stager.sv
// Self-checking bench for rtlola_input_stager: queue-based event model plus directed literal checks.
// Expected ev_time follows RTLOLA_STAGER_TIMESTAMP_EN the same way the design does.
module tb_rtlola_input_stager;

  localparam int NI     = 2;
  localparam int DW     = 64;
  localparam int STAGES = 4;
  localparam int DEPTH  = 8;
  localparam int TW     = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [NI*DW-1:0]  in_data = '0;
  logic [NI-1:0]     in_valid = '0;
  logic              in_new = 1'b0;
  logic              in_ready;
  logic [1:0]        stage;
  logic              hlc_tick;
  logic              ev_new;
  logic [NI-1:0]     ev_valid;
  logic [NI*DW-1:0]  ev_data;
  logic [TW-1:0]     ev_time;
  logic              overflow;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  rtlola_input_stager #(
    .NUM_INPUTS (NI),
    .DATA_W     (DW),
    .STAGES     (STAGES),
    .DEPTH      (DEPTH),
    .TIME_W     (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_new   (in_new),
    .in_ready (in_ready),
    .stage    (stage),
    .hlc_tick (hlc_tick),
    .ev_new   (ev_new),
    .ev_valid (ev_valid),
    .ev_data  (ev_data),
    .ev_time  (ev_time),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: enabled-cycle count gives stage and timestamp; a queue holds pending events.
  typedef struct {
    logic [NI-1:0]    v;
    logic [NI*DW-1:0] d;
    logic [TW-1:0]    t;
  } ev_t;

  ev_t               q[$];
  longint unsigned   en_cycles = 0;
  logic              m_ev_new = 1'b0;
  logic [NI-1:0]     m_ev_valid = '0;
  logic [NI*DW-1:0]  m_ev_data = '0;
  logic [TW-1:0]     m_ev_time = '0;
  logic              m_overflow = 1'b0;

  always @(posedge clk) begin
    int  occ;
    bit  release_now;
    ev_t e;
    if (rst) begin
      q.delete();
      en_cycles  = 0;
      m_ev_new   = 1'b0;
      m_ev_valid = '0;
      m_ev_data  = '0;
      m_ev_time  = '0;
      m_overflow = 1'b0;
    end else begin
      occ = q.size();
      release_now = en && ((en_cycles % STAGES) == STAGES - 1) && (occ > 0);
      if (in_new && (in_valid != '0)) begin
        if (occ < DEPTH) begin
          e.v = in_valid;
          e.d = in_data;
          e.t = TW'(en_cycles);
          q.push_back(e);
        end else begin
          m_overflow = 1'b1;
        end
      end
      if (release_now) begin
        e = q.pop_front();
        m_ev_new   = 1'b1;
        m_ev_valid = e.v;
        m_ev_data  = e.d;
`ifdef RTLOLA_STAGER_TIMESTAMP_EN
        m_ev_time  = e.t;
`else
        m_ev_time  = '0;
`endif
      end else begin
        m_ev_new   = 1'b0;
        m_ev_valid = '0;
      end
      if (en) en_cycles++;
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit n,
                               input logic [NI-1:0] v, input logic [NI*DW-1:0] d);
    @(posedge clk);
    #1;
    rst      = r;
    en       = e;
    in_new   = n;
    in_valid = v;
    in_data  = d;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("stage",    256'(stage),    256'(en_cycles % STAGES));
      checkOutput("hlc_tick", 256'(hlc_tick), 256'(en && ((en_cycles % STAGES) == 0)));
      checkOutput("in_ready", 256'(in_ready), 256'(q.size() < DEPTH));
      checkOutput("ev_new",   256'(ev_new),   256'(m_ev_new));
      checkOutput("ev_valid", 256'(ev_valid), 256'(m_ev_valid));
      checkOutput("ev_data",  256'(ev_data),  256'(m_ev_data));
      checkOutput("ev_time",  256'(ev_time),  256'(m_ev_time));
      checkOutput("overflow", 256'(overflow), 256'(m_overflow));
    end
  end

  function automatic logic [NI*DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [TW-1:0] exp_time;
    logic [NI-1:0] v;

    // Reset for two edges, then pin the reset state with literals.
    applyStimulus(1, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, '0, '0);
    @(negedge clk);
    chk_on = 1'b1;
    checkOutput("rst_stage",    256'(stage),    256'(0));
    checkOutput("rst_in_ready", 256'(in_ready), 256'(1));
    checkOutput("rst_ev_new",   256'(ev_new),   256'(0));
    checkOutput("rst_ev_data",  256'(ev_data),  256'(0));
    checkOutput("rst_overflow", 256'(overflow), 256'(0));

    // Single push at stage 1 appears at the next stage 0, two cycles after the push edge.
    applyStimulus(0, 1, 0, '0, '0);
    applyStimulus(0, 1, 1, 2'b01, {64'd0, 64'd1});
    applyStimulus(0, 1, 0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef RTLOLA_STAGER_TIMESTAMP_EN
    exp_time = 64'd1;
`else
    exp_time = 64'd0;
`endif
    checkOutput("lat_ev_new",   256'(ev_new),       256'(1));
    checkOutput("lat_stage",    256'(stage),        256'(0));
    checkOutput("lat_ev_valid", 256'(ev_valid),     256'(2'b01));
    checkOutput("lat_ev_data",  256'(ev_data[63:0]), 256'(64'd1));
    checkOutput("lat_ev_time",  256'(ev_time),      256'(exp_time));

    // Event with no presence bits is ignored; then overfill with en low.
    applyStimulus(1, 0, 0, '0, '0);
    applyStimulus(0, 0, 1, 2'b00, rand_data());
    applyStimulus(0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("nv_overflow", 256'(overflow), 256'(0));
    checkOutput("nv_in_ready", 256'(in_ready), 256'(1));
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = NI'($urandom_range(1, 3));
      applyStimulus(0, 0, 1, v, rand_data());
    end
    applyStimulus(0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("full_in_ready", 256'(in_ready), 256'(0));
    checkOutput("full_overflow", 256'(overflow), 256'(1));

    // Drain the backlog; overflow must remain sticky throughout.
    for (int i = 0; i < DEPTH * STAGES + 8; i++) applyStimulus(0, 1, 0, '0, '0);

    // Back-to-back pushes in one HLC cycle, then reset with events still queued.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 2'b11, rand_data());
    for (int i = 0; i < 14; i++) applyStimulus(0, 1, 0, '0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 2'b10, rand_data());
    applyStimulus(0, 1, 0, '0, '0);
    applyStimulus(0, 1, 0, '0, '0);
    applyStimulus(1, 1, 0, '0, '0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, '0, '0);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) < 4),
                    NI'($urandom_range(0, 3)),
                    rand_data());
    end
    applyStimulus(0, 1, 0, '0, '0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
